vsync_timing_gen: RTL and testbench

- Parametrised vertical timing generator for the HDMI overlay video path.
- Counts line-end strobes from the horizontal timing chain.
- Sequences each frame through active, front-porch, sync and back-porch regions.
- Drives a polarity-configurable vSyncPulse, a vActive qualifier, the current line number, and frame boundary strobes for the overlay compositor.

---
 rtl/vsync_pkg.sv | 25 ++
 rtl/vsync_timing_gen_if.sv | 37 +++
 rtl/vsync_cfg_shadow.sv | 64 ++++++
 rtl/vsync_timing_gen.sv | 122 ++++++++++++
 tb/tb_vsync_timing_gen.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/vsync_pkg.sv
// rtl/vsync_pkg.sv - shared states and standard timing sets for the vertical timing generator
package vsync_pkg;

    typedef enum logic [1:0] {
        VS_ACTIVE = 2'd0,
        VS_FRONT  = 2'd1,
        VS_SYNC   = 2'd2,
        VS_BACK   = 2'd3
    } vsState_t;

    typedef struct packed {
        int active;
        int front;
        int syncLen;
        int back;
    } vsTiming_t;

    localparam vsTiming_t TIMING_1080P60 = '{active: 1080, front: 4, syncLen: 5, back: 36};
    localparam vsTiming_t TIMING_720P60  = '{active: 720,  front: 5, syncLen: 5, back: 20};

    function automatic int timingTotal(input vsTiming_t t);
        return t.active + t.front + t.syncLen + t.back;
    endfunction

endpackage

// File: rtl/vsync_timing_gen_if.sv
// rtl/vsync_timing_gen_if.sv - line strobe in, vertical timing out; cfg signals under VSYNC_RUNTIME_CFG_EN
interface vsync_timing_gen_if #(
    parameter int busWidth = 11
);
    logic                lineEnd;
    logic [busWidth-1:0] lineCount;
    logic                vSyncPulse;
    logic                vActive;
    logic                frameStart;
    logic                frameEnd;
`ifdef VSYNC_RUNTIME_CFG_EN
    logic [busWidth-1:0] cfgActive;
    logic [busWidth-1:0] cfgFront;
    logic [busWidth-1:0] cfgSync;
    logic [busWidth-1:0] cfgBack;
    logic                cfgLoad;
    logic                cfgPending;

    modport master (
        input  lineEnd, cfgActive, cfgFront, cfgSync, cfgBack, cfgLoad,
        output lineCount, vSyncPulse, vActive, frameStart, frameEnd, cfgPending
    );
    modport slave (
        output lineEnd, cfgActive, cfgFront, cfgSync, cfgBack, cfgLoad,
        input  lineCount, vSyncPulse, vActive, frameStart, frameEnd, cfgPending
    );
`else
    modport master (
        input  lineEnd,
        output lineCount, vSyncPulse, vActive, frameStart, frameEnd
    );
    modport slave (
        output lineEnd,
        input  lineCount, vSyncPulse, vActive, frameStart, frameEnd
    );
`endif
endinterface

// File: rtl/vsync_cfg_shadow.sv
// rtl/vsync_cfg_shadow.sv - shadow/live timing registers committed at frame wrap (VSYNC_RUNTIME_CFG_EN)
module vsync_cfg_shadow #(
    parameter int busWidth  = 11,
    parameter int defActive = 1080,
    parameter int defFront  = 4,
    parameter int defSync   = 5,
    parameter int defBack   = 36
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                commit,
    input  logic                cfgLoad,
    input  logic [busWidth-1:0] cfgActive,
    input  logic [busWidth-1:0] cfgFront,
    input  logic [busWidth-1:0] cfgSync,
    input  logic [busWidth-1:0] cfgBack,
    output logic [busWidth-1:0] liveActive,
    output logic [busWidth-1:0] liveFront,
    output logic [busWidth-1:0] liveSync,
    output logic [busWidth-1:0] liveBack,
    output logic                cfgPending
);
    localparam logic [busWidth+1:0] maxTotal = {2'b00, {busWidth{1'b1}}};

    logic [busWidth-1:0] shActive, shFront, shSync, shBack;
    logic [busWidth+1:0] shTotal;
    logic                shValid;

    // Two guard bits so the sum of four fields cannot wrap before the range check.
    assign shTotal = {2'b00, shActive} + {2'b00, shFront} + {2'b00, shSync} + {2'b00, shBack};
    assign shValid = (shActive != '0) && (shSync != '0) && (shTotal <= maxTotal);

    always_ff @(posedge clock) begin
        if (reset) begin
            shActive   <= busWidth'(defActive);
            shFront    <= busWidth'(defFront);
            shSync     <= busWidth'(defSync);
            shBack     <= busWidth'(defBack);
            liveActive <= busWidth'(defActive);
            liveFront  <= busWidth'(defFront);
            liveSync   <= busWidth'(defSync);
            liveBack   <= busWidth'(defBack);
            cfgPending <= 1'b0;
        end else begin
            if (commit && cfgPending) begin
                if (shValid) begin
                    liveActive <= shActive;
                    liveFront  <= shFront;
                    liveSync   <= shSync;
                    liveBack   <= shBack;
                end
                cfgPending <= 1'b0;
            end
            // A load coinciding with the wrap stays pending for the following frame.
            if (cfgLoad) begin
                shActive   <= cfgActive;
                shFront    <= cfgFront;
                shSync     <= cfgSync;
                shBack     <= cfgBack;
                cfgPending <= 1'b1;
            end
        end
    end
endmodule

// File: rtl/vsync_timing_gen.sv
// rtl/vsync_timing_gen.sv - vertical timing generator; VSYNC_RUNTIME_CFG_EN adds frame-synchronous timing reload
module vsync_timing_gen
    import vsync_pkg::*;
#(
    parameter int busWidth     = 11,
    parameter int activeLines  = TIMING_1080P60.active,
    parameter int frontPorch   = TIMING_1080P60.front,
    parameter int syncLines    = TIMING_1080P60.syncLen,
    parameter int backPorch    = TIMING_1080P60.back,
    parameter bit syncPolarity = 1'b1
) (
    input logic              clock,
    input logic              reset,
    vsync_timing_gen_if.master bus
);
    localparam int total = activeLines + frontPorch + syncLines + backPorch;

    if (activeLines < 1 || syncLines < 1 || frontPorch < 0 || backPorch < 0
        || total > (2 ** busWidth) - 1) begin : gBadTiming
        $error("vsync_timing_gen: invalid timing parameters");
    end

    vsState_t            state, stateNext;
    logic [busWidth-1:0] lineCount, countNext;
    logic                vActiveR, vSyncR, frameStartR, frameEndR;
    logic                vActiveNext, vSyncNext, frameStartNext, frameEndNext;
    logic [busWidth-1:0] endActive, endFront, endSync, lastLine;
    logic                frontEmpty;
    logic                wrap;

`ifdef VSYNC_RUNTIME_CFG_EN
    logic [busWidth-1:0] liveActive, liveFront, liveSync, liveBack;

    vsync_cfg_shadow #(
        .busWidth (busWidth),
        .defActive(activeLines),
        .defFront (frontPorch),
        .defSync  (syncLines),
        .defBack  (backPorch)
    ) uShadow (
        .clock     (clock),
        .reset     (reset),
        .commit    (wrap),
        .cfgLoad   (bus.cfgLoad),
        .cfgActive (bus.cfgActive),
        .cfgFront  (bus.cfgFront),
        .cfgSync   (bus.cfgSync),
        .cfgBack   (bus.cfgBack),
        .liveActive(liveActive),
        .liveFront (liveFront),
        .liveSync  (liveSync),
        .liveBack  (liveBack),
        .cfgPending(bus.cfgPending)
    );

    assign endActive  = liveActive - busWidth'(1);
    assign endFront   = endActive + liveFront;
    assign endSync    = endFront + liveSync;
    assign lastLine   = endSync + liveBack;
    assign frontEmpty = (liveFront == '0);
`else
    assign endActive  = busWidth'(activeLines - 1);
    assign endFront   = busWidth'(activeLines + frontPorch - 1);
    assign endSync    = busWidth'(activeLines + frontPorch + syncLines - 1);
    assign lastLine   = busWidth'(total - 1);
    assign frontEmpty = (frontPorch == 0);
`endif

    assign wrap = bus.lineEnd && (lineCount == lastLine);

    // An empty back porch needs no special case: the sync end is then the wrap line.
    always_comb begin
        stateNext      = state;
        countNext      = lineCount;
        frameStartNext = 1'b0;
        frameEndNext   = 1'b0;
        if (bus.lineEnd) begin
            if (wrap) begin
                countNext      = '0;
                stateNext      = VS_ACTIVE;
                frameStartNext = 1'b1;
            end else begin
                countNext = lineCount + busWidth'(1);
                unique case (state)
                    VS_ACTIVE: if (lineCount == endActive) begin
                        frameEndNext = 1'b1;
                        stateNext    = frontEmpty ? VS_SYNC : VS_FRONT;
                    end
                    VS_FRONT:  if (lineCount == endFront) stateNext = VS_SYNC;
                    VS_SYNC:   if (lineCount == endSync)  stateNext = VS_BACK;
                    VS_BACK:   stateNext = state;
                endcase
            end
        end
        vActiveNext = (stateNext == VS_ACTIVE);
        vSyncNext   = (stateNext == VS_SYNC) ? syncPolarity : ~syncPolarity;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= VS_ACTIVE;
            lineCount   <= '0;
            vActiveR    <= 1'b1;
            vSyncR      <= ~syncPolarity;
            frameStartR <= 1'b0;
            frameEndR   <= 1'b0;
        end else begin
            state       <= stateNext;
            lineCount   <= countNext;
            vActiveR    <= vActiveNext;
            vSyncR      <= vSyncNext;
            frameStartR <= frameStartNext;
            frameEndR   <= frameEndNext;
        end
    end

    assign bus.lineCount  = lineCount;
    assign bus.vActive    = vActiveR;
    assign bus.vSyncPulse = vSyncR;
    assign bus.frameStart = frameStartR;
    assign bus.frameEnd   = frameEndR;
endmodule

// File: tb/tb_vsync_timing_gen.sv
// tb/tb_vsync_timing_gen.sv - three timing variants checked by vector table, corner sequences and random model
module tb_vsync_timing_gen;
    logic clock = 1'b0;
    logic rst   = 1'b1;
    logic le    = 1'b0;
    int   checks = 0;
    int   passes = 0;

    always #5 clock = ~clock;

    vsync_timing_gen_if #(.busWidth(4)) b0 ();
    vsync_timing_gen_if #(.busWidth(4)) b1 ();
    vsync_timing_gen_if #(.busWidth(4)) b2 ();

    assign b0.lineEnd = le;
    assign b1.lineEnd = le;
    assign b2.lineEnd = le;

`ifdef VSYNC_RUNTIME_CFG_EN
    logic [3:0] cA = '0, cF = '0, cS = '0, cB = '0;
    logic       cLoad = 1'b0;
    assign b0.cfgActive = cA; assign b0.cfgFront = cF; assign b0.cfgSync = cS; assign b0.cfgBack = cB;
    assign b1.cfgActive = cA; assign b1.cfgFront = cF; assign b1.cfgSync = cS; assign b1.cfgBack = cB;
    assign b2.cfgActive = cA; assign b2.cfgFront = cF; assign b2.cfgSync = cS; assign b2.cfgBack = cB;
    assign b0.cfgLoad = cLoad;
    assign b1.cfgLoad = 1'b0;
    assign b2.cfgLoad = 1'b0;
`endif

    vsync_timing_gen #(.busWidth(4), .activeLines(4), .frontPorch(1), .syncLines(2), .backPorch(1),
        .syncPolarity(1'b1)) u0 (.clock(clock), .reset(rst), .bus(b0));
    vsync_timing_gen #(.busWidth(4), .activeLines(4), .frontPorch(0), .syncLines(2), .backPorch(0),
        .syncPolarity(1'b1)) u1 (.clock(clock), .reset(rst), .bus(b1));
    vsync_timing_gen #(.busWidth(4), .activeLines(3), .frontPorch(2), .syncLines(1), .backPorch(2),
        .syncPolarity(1'b0)) u2 (.clock(clock), .reset(rst), .bus(b2));

    logic [3:0] gLine [3];
    logic       gAct [3], gSync [3], gFs [3], gFe [3];
    assign gLine[0] = b0.lineCount; assign gAct[0] = b0.vActive; assign gSync[0] = b0.vSyncPulse;
    assign gFs[0] = b0.frameStart;  assign gFe[0] = b0.frameEnd;
    assign gLine[1] = b1.lineCount; assign gAct[1] = b1.vActive; assign gSync[1] = b1.vSyncPulse;
    assign gFs[1] = b1.frameStart;  assign gFe[1] = b1.frameEnd;
    assign gLine[2] = b2.lineCount; assign gAct[2] = b2.vActive; assign gSync[2] = b2.vSyncPulse;
    assign gFs[2] = b2.frameStart;  assign gFe[2] = b2.frameEnd;

    // Reference: frame position as an integer line index, regions by interval arithmetic.
    int pA [3] = '{4, 4, 3};
    int pF [3] = '{1, 0, 2};
    int pS [3] = '{2, 2, 1};
    int pB [3] = '{1, 0, 2};
    bit pPol [3] = '{1'b1, 1'b1, 1'b0};
    int n [3]   = '{0, 0, 0};
    bit eFs [3] = '{0, 0, 0};
    bit eFe [3] = '{0, 0, 0};

    typedef struct {
        bit r; bit l; int line; bit act; bit sync; bit fs; bit fe;
    } vec_t;
    vec_t tbl [18];

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got == exp) passes++;
        else $display("FAIL %s got=%0d expected=%0d", name, got, exp);
    endtask

    task automatic modelStep(input bit r, input bit l);
        for (int i = 0; i < 3; i++) begin
            int tot;
            tot = pA[i] + pF[i] + pS[i] + pB[i];
            if (r) begin
                n[i] = 0; eFs[i] = 0; eFe[i] = 0;
            end else if (l) begin
                eFe[i] = (n[i] == pA[i] - 1);
                eFs[i] = (n[i] == tot - 1);
                n[i]   = (n[i] + 1) % tot;
            end else begin
                eFs[i] = 0; eFe[i] = 0;
            end
        end
    endtask

    task automatic apply(input bit r, input bit l);
        rst = r;
        le  = l;
        @(posedge clock);
        #1;
        modelStep(r, l);
    endtask

    task automatic checkModel(input int i);
        bit inSync;
        inSync = (n[i] >= pA[i] + pF[i]) && (n[i] < pA[i] + pF[i] + pS[i]);
        chk($sformatf("dut%0d.line", i), gLine[i], n[i]);
        chk($sformatf("dut%0d.vActive", i), gAct[i], int'(n[i] < pA[i]));
        chk($sformatf("dut%0d.vSync", i), gSync[i], int'(inSync ? pPol[i] : !pPol[i]));
        chk($sformatf("dut%0d.frameStart", i), gFs[i], eFs[i]);
        chk($sformatf("dut%0d.frameEnd", i), gFe[i], eFe[i]);
    endtask

    initial begin
        tbl = '{
            '{1, 0, 0, 1, 0, 0, 0}, '{0, 1, 1, 1, 0, 0, 0}, '{0, 1, 2, 1, 0, 0, 0},
            '{0, 1, 3, 1, 0, 0, 0}, '{0, 0, 3, 1, 0, 0, 0}, '{0, 1, 4, 0, 0, 0, 1},
            '{0, 0, 4, 0, 0, 0, 0}, '{0, 1, 5, 0, 1, 0, 0}, '{0, 1, 6, 0, 1, 0, 0},
            '{0, 1, 7, 0, 0, 0, 0}, '{0, 1, 0, 1, 0, 1, 0}, '{0, 0, 0, 1, 0, 0, 0},
            '{0, 1, 1, 1, 0, 0, 0}, '{0, 1, 2, 1, 0, 0, 0}, '{0, 1, 3, 1, 0, 0, 0},
            '{0, 1, 4, 0, 0, 0, 1}, '{0, 1, 5, 0, 1, 0, 0}, '{1, 1, 0, 1, 0, 0, 0}
        };

        for (int k = 0; k < 18; k++) begin
            apply(tbl[k].r, tbl[k].l);
            chk($sformatf("vec%0d.line", k), gLine[0], tbl[k].line);
            chk($sformatf("vec%0d.vActive", k), gAct[0], tbl[k].act);
            chk($sformatf("vec%0d.vSync", k), gSync[0], tbl[k].sync);
            chk($sformatf("vec%0d.frameStart", k), gFs[0], tbl[k].fs);
            chk($sformatf("vec%0d.frameEnd", k), gFe[0], tbl[k].fe);
            checkModel(1);
            checkModel(2);
        end

        // Porch-less variant and negative polarity around the sync region.
        apply(1, 0);
        chk("pol0.resetSync", gSync[2], 1);
        chk("pol1.resetSync", gSync[1], 0);
        repeat (4) apply(0, 1);
        chk("noPorch.line4", gLine[1], 4);
        chk("noPorch.sync4", gSync[1], 1);
        chk("noPorch.act4", gAct[1], 0);
        chk("noPorch.fe4", gFe[1], 1);
        apply(0, 1);
        chk("noPorch.sync5", gSync[1], 1);
        chk("pol0.sync5", gSync[2], 0);
        chk("pol0.act5", gAct[2], 0);
        apply(0, 1);
        chk("noPorch.wrapLine", gLine[1], 0);
        chk("noPorch.wrapFs", gFs[1], 1);
        chk("noPorch.wrapSync", gSync[1], 0);
        chk("pol0.sync6", gSync[2], 1);
        chk("pol0.line6", gLine[2], 6);

        // Regular lineEnd every 4 clocks, then random gaps, bursts and resets.
        apply(1, 0);
        for (int c = 0; c < 700; c++) begin
            bit r, l;
            if (c < 80) begin
                r = 1'b0;
                l = (c % 4 == 3);
            end else begin
                r = ($urandom_range(0, 79) == 0);
                l = ($urandom_range(0, 2) != 0);
            end
            apply(r, l);
            for (int i = 0; i < 3; i++) checkModel(i);
        end

`ifdef VSYNC_RUNTIME_CFG_EN
        begin
            int cnt;
            bit seen;
            apply(1, 0);
            apply(0, 1);
            apply(0, 1);
            cA = 4'd2; cF = 4'd1; cS = 4'd1; cB = 4'd1; cLoad = 1'b1;
            apply(0, 0);
            cLoad = 1'b0;
            chk("cfg.pendingSet", b0.cfgPending, 1);
            for (int pass = 0; pass < 2; pass++) begin
                seen = 1'b0;
                for (int k = 0; k < 20 && !seen; k++) begin
                    apply(0, 1);
                    seen = gFs[0];
                end
                chk($sformatf("cfg%0d.wrapSeen", pass), seen, 1);
                chk($sformatf("cfg%0d.pendingClr", pass), b0.cfgPending, 0);
                cnt = 0;
                seen = 1'b0;
                for (int k = 0; k < 20 && !seen; k++) begin
                    apply(0, 1);
                    cnt++;
                    seen = gFs[0];
                end
                chk($sformatf("cfg%0d.total", pass), cnt, 5);
                if (pass == 0) begin
                    cS = 4'd0; cLoad = 1'b1;
                    apply(0, 0);
                    cLoad = 1'b0;
                    chk("cfg.badPending", b0.cfgPending, 1);
                end
            end
        end
`endif

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
